// File: rtl/pipe_trace_monitor.sv
// Pipeline slot tracker: rebuilds per-stage instr/kind, flags the retiring slot and, with PIPE_TRACE_PERF_EN, keeps saturating counters.
// Latency: stages 0/1 combinational, stage 2 one edge, last stage STAGES-2 edges after entering stage 1.
// Backpressure: none; every registered stage shifts on every edge and never stalls.
module pipe_trace_monitor #(
    parameter int STAGES = 5,
    parameter int IW     = 32,
    parameter int CNT_W  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [IW-1:0]        if_instr,
    input  logic [IW-1:0]        id_instr,
    input  logic                 pcsrc,
    input  logic                 bubble,
    output logic [STAGES*IW-1:0] stage_instr,
    output logic [STAGES*2-1:0]  stage_kind,
    output logic                 retire_valid,
    output logic [IW-1:0]        retire_instr,
    output logic [CNT_W-1:0]     retire_count,
    output logic [CNT_W-1:0]     flush_count,
    output logic [CNT_W-1:0]     bubble_count
);

    typedef enum logic [1:0] {
        KIND_VALID  = 2'b00,
        KIND_NOP    = 2'b01,
        KIND_BUBBLE = 2'b10,
        KIND_FLUSH  = 2'b11
    } kind_t;

    kind_t         kind0;
    kind_t         kind1;
    logic          flush_id;
    logic [IW-1:0] pipe_instr [2:STAGES-1];
    kind_t         pipe_kind  [2:STAGES-1];

    // The branch itself sits in ID, so pcsrc only squashes the IF slot now
    // and reaches the ID slot one edge later through flush_id.
    always_comb begin
        kind0 = KIND_VALID;
        if (pcsrc)
            kind0 = KIND_FLUSH;
        else if (if_instr == '0)
            kind0 = KIND_NOP;
    end

    always_comb begin
        kind1 = KIND_VALID;
        if (flush_id)
            kind1 = KIND_FLUSH;
        else if (id_instr == '0)
            kind1 = KIND_NOP;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flush_id <= 1'b0;
            for (int k = 2; k < STAGES; k++) begin
                pipe_instr[k] <= '0;
                pipe_kind[k]  <= KIND_NOP;
            end
        end else begin
            flush_id      <= pcsrc;
            pipe_instr[2] <= id_instr;
            pipe_kind[2]  <= bubble ? KIND_BUBBLE : kind1;
            for (int k = 3; k < STAGES; k++) begin
                pipe_instr[k] <= pipe_instr[k-1];
                pipe_kind[k]  <= pipe_kind[k-1];
            end
        end
    end

    assign stage_instr[0 +: IW] = if_instr;
    assign stage_instr[IW +: IW] = id_instr;
    assign stage_kind[1:0] = kind0;
    assign stage_kind[3:2] = kind1;

    for (genvar g = 2; g < STAGES; g++) begin : g_stage_out
        assign stage_instr[g*IW +: IW] = pipe_instr[g];
        assign stage_kind[g*2 +: 2]    = pipe_kind[g];
    end

    assign retire_valid = (pipe_kind[STAGES-1] == KIND_VALID);
    assign retire_instr = pipe_instr[STAGES-1];

`ifdef PIPE_TRACE_PERF_EN
    logic [CNT_W-1:0] retire_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    // Counters hold at all-ones rather than wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retire_cnt <= '0;
            flush_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (retire_valid && retire_cnt != '1)
                retire_cnt <= retire_cnt + CNT_W'(1);
            if (pcsrc && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
            if (bubble && bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

    assign retire_count = retire_cnt;
    assign flush_count  = flush_cnt;
    assign bubble_count = bubble_cnt;
`else
    assign retire_count = '0;
    assign flush_count  = '0;
    assign bubble_count = '0;
`endif

endmodule

// File: tb/tb_pipe_trace_monitor.sv
// Bench for pipe_trace_monitor: a 5-stage/16-bit and a 7-stage/4-bit instance share stimulus; a queue scoreboard per instance predicts registered stages.
module tb_pipe_trace_monitor;

    localparam int IW = 32;

    logic          clock;
    logic          reset;
    logic [IW-1:0] if_instr;
    logic [IW-1:0] id_instr;
    logic          pcsrc;
    logic          bubble;

    logic [5*IW-1:0] d5_instr;
    logic [5*2-1:0]  d5_kind;
    logic            d5_rvld;
    logic [IW-1:0]   d5_rinstr;
    logic [15:0]     d5_ret, d5_flush, d5_bub;

    logic [7*IW-1:0] d7_instr;
    logic [7*2-1:0]  d7_kind;
    logic            d7_rvld;
    logic [IW-1:0]   d7_rinstr;
    logic [3:0]      d7_ret, d7_flush, d7_bub;

    pipe_trace_monitor #(.STAGES(5), .IW(IW), .CNT_W(16)) u_dut5 (
        .clock(clock), .reset(reset), .if_instr(if_instr), .id_instr(id_instr),
        .pcsrc(pcsrc), .bubble(bubble), .stage_instr(d5_instr), .stage_kind(d5_kind),
        .retire_valid(d5_rvld), .retire_instr(d5_rinstr), .retire_count(d5_ret),
        .flush_count(d5_flush), .bubble_count(d5_bub)
    );

    pipe_trace_monitor #(.STAGES(7), .IW(IW), .CNT_W(4)) u_dut7 (
        .clock(clock), .reset(reset), .if_instr(if_instr), .id_instr(id_instr),
        .pcsrc(pcsrc), .bubble(bubble), .stage_instr(d7_instr), .stage_kind(d7_kind),
        .retire_valid(d7_rvld), .retire_instr(d7_rinstr), .retire_count(d7_ret),
        .flush_count(d7_flush), .bubble_count(d7_bub)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct packed {
        logic [IW-1:0] instr;
        logic [1:0]    kind;
    } ent_t;

    ent_t q5[$];
    ent_t q7[$];
    int   ret5, ret7, nflush, nbub;
    logic m_flush_id;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] kind_of(input logic flag, input logic [IW-1:0] w);
        if (flag) return 2'b11;
        if (w == '0) return 2'b01;
        return 2'b00;
    endfunction

    // Expected counter value: saturated model count, or zero when counters are compiled out.
    function automatic logic [63:0] cexp(input int v, input int w);
        int m;
        m = (1 << w) - 1;
`ifdef PIPE_TRACE_PERF_EN
        return 64'((v > m) ? m : v);
`else
        return 64'(0 * m * v);
`endif
    endfunction

    task automatic reset_model();
        ent_t e;
        e.instr = '0;
        e.kind  = 2'b01;
        q5.delete();
        q7.delete();
        for (int i = 0; i < 3; i++) q5.push_back(e);
        for (int i = 0; i < 5; i++) q7.push_back(e);
        ret5 = 0; ret7 = 0; nflush = 0; nbub = 0;
        m_flush_id = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        for (int k = 2; k < 5; k++) begin
            check($sformatf("%s_d5_kind%0d", tag, k), 64'(d5_kind[k*2 +: 2]), 64'(2'b01));
            check($sformatf("%s_d5_instr%0d", tag, k), 64'(d5_instr[k*IW +: IW]), 64'(0));
        end
        for (int k = 2; k < 7; k++)
            check($sformatf("%s_d7_kind%0d", tag, k), 64'(d7_kind[k*2 +: 2]), 64'(2'b01));
        check({tag, "_d5_rvld"}, 64'(d5_rvld), 64'(0));
        check({tag, "_d5_rinstr"}, 64'(d5_rinstr), 64'(0));
        check({tag, "_d7_rvld"}, 64'(d7_rvld), 64'(0));
        check({tag, "_d5_ret"}, 64'(d5_ret), 64'(0));
        check({tag, "_d5_flush"}, 64'(d5_flush), 64'(0));
        check({tag, "_d5_bub"}, 64'(d5_bub), 64'(0));
        check({tag, "_d7_ret"}, 64'(d7_ret), 64'(0));
    endtask

    // One cycle: drive inputs, check combinational stages, push the expected
    // stage-2 entry, pop the retiring one, then check registered state after the edge.
    task automatic step(input logic [IW-1:0] ifw, input logic [IW-1:0] idw,
                        input logic pc, input logic bb);
        ent_t       e;
        logic [1:0] k1;
        if_instr = ifw;
        id_instr = idw;
        pcsrc    = pc;
        bubble   = bb;
        #2;
        k1 = kind_of(m_flush_id, idw);
        check("s0_instr", 64'(d5_instr[0 +: IW]), 64'(ifw));
        check("s0_kind", 64'(d5_kind[1:0]), 64'(kind_of(pc, ifw)));
        check("s1_instr", 64'(d5_instr[IW +: IW]), 64'(idw));
        check("s1_kind", 64'(d5_kind[3:2]), 64'(k1));
        check("d7_s1_kind", 64'(d7_kind[3:2]), 64'(k1));

        e.instr = idw;
        e.kind  = bb ? 2'b10 : k1;
        if (q5[0].kind == 2'b00) ret5++;
        if (q7[0].kind == 2'b00) ret7++;
        q5.push_back(e);
        void'(q5.pop_front());
        q7.push_back(e);
        void'(q7.pop_front());
        if (pc) nflush++;
        if (bb) nbub++;
        m_flush_id = pc;

        @(posedge clock);
        #1;
        for (int i = 0; i < q5.size(); i++) begin
            check($sformatf("d5_kind%0d", 4 - i), 64'(d5_kind[(4-i)*2 +: 2]), 64'(q5[i].kind));
            check($sformatf("d5_instr%0d", 4 - i), 64'(d5_instr[(4-i)*IW +: IW]), 64'(q5[i].instr));
        end
        for (int i = 0; i < q7.size(); i++) begin
            check($sformatf("d7_kind%0d", 6 - i), 64'(d7_kind[(6-i)*2 +: 2]), 64'(q7[i].kind));
            check($sformatf("d7_instr%0d", 6 - i), 64'(d7_instr[(6-i)*IW +: IW]), 64'(q7[i].instr));
        end
        check("d5_rvld", 64'(d5_rvld), 64'(q5[0].kind == 2'b00));
        check("d5_rinstr", 64'(d5_rinstr), 64'(q5[0].instr));
        check("d7_rvld", 64'(d7_rvld), 64'(q7[0].kind == 2'b00));
        check("d7_rinstr", 64'(d7_rinstr), 64'(q7[0].instr));
        check("d5_ret", 64'(d5_ret), cexp(ret5, 16));
        check("d5_flush", 64'(d5_flush), cexp(nflush, 16));
        check("d5_bub", 64'(d5_bub), cexp(nbub, 16));
        check("d7_ret", 64'(d7_ret), cexp(ret7, 4));
        check("d7_flush", 64'(d7_flush), cexp(nflush, 4));
        check("d7_bub", 64'(d7_bub), cexp(nbub, 4));
    endtask

    initial begin
        logic [IW-1:0] w;
        reset    = 1'b0;
        if_instr = 32'h2009_0004;
        id_instr = 32'h0109_5020;
        pcsrc    = 1'b0;
        bubble   = 1'b0;
        reset_model();

        // Held in reset with nonzero inputs, across one clock edge.
        #3;
        check("rst_s0_instr", 64'(d5_instr[0 +: IW]), 64'h2009_0004);
        check("rst_s1_instr", 64'(d5_instr[IW +: IW]), 64'h0109_5020);
        check("rst_s1_kind", 64'(d5_kind[3:2]), 64'(2'b00));
        #4;
        check_cleared("rst");
        #1 reset = 1'b1;

        // Straight-line retire.
        step(32'h1111_0001, 32'h0109_5020, 1'b0, 1'b0);
        step(32'h1111_0002, 32'h8D4F_0008, 1'b0, 1'b0);
        step(32'h1111_0003, 32'h0124_4822, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(32'h0, 32'h0, 1'b0, 1'b0);
        check("straight_ret3", 64'(d5_ret), cexp(3, 16));

        // Branch flush: squashed fetch enters ID next cycle and must read FLUSH.
        step(32'hDEAD_0001, 32'h1000_FFFF, 1'b1, 1'b0);
        step(32'h0000_0000, 32'hDEAD_0001, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(32'h0, 32'h0, 1'b0, 1'b0);

        // Load-use bubble alone, then bubble together with a branch.
        step(32'h2222_0001, 32'h8C48_0000, 1'b0, 1'b1);
        step(32'h2222_0002, 32'h0109_5020, 1'b1, 1'b1);
        step(32'h2222_0003, 32'h2222_0002, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(32'h0, 32'h0, 1'b0, 1'b0);

        // Long valid run drives the 4-bit counter into saturation.
        for (int i = 0; i < 24; i++) step(32'h3000_0000 + i, 32'h4000_0001 + i, 1'b0, 1'b0);

        // Mixed random traffic.
        for (int i = 0; i < 40; i++) begin
            w = $urandom();
            if ($urandom_range(0, 4) == 0) w = '0;
            step($urandom(), w, ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
        end

        // Asynchronous reset between edges.
        #2 reset = 1'b0;
        #1;
        check_cleared("midrst");
        #1 reset = 1'b1;
        reset_model();

        // Single valid word through the 7-stage instance after reset.
        step(32'h0, 32'h0BAD_F00D, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(32'h0, 32'h0, 1'b0, 1'b0);
        check("d7_lat_rvld", 64'(d7_rvld), 64'(1));
        check("d7_lat_ret_before", 64'(d7_ret), cexp(0, 4));
        step(32'h0, 32'h0, 1'b0, 1'b0);
        check("d7_lat_ret_after", 64'(d7_ret), cexp(1, 4));
        for (int i = 0; i < 3; i++) step(32'h0, 32'h0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
